// File: rtl/rs232_avm_scheduler.sv
// rs232_avm_scheduler
// Avalon-MM master that time-shares one RS232 UART core between a receive
// stream and a transmit requester. It polls the UART status register and
// then performs at most one data read (RX) or one data write (TX) per poll.
// Received bytes land in a small first-word-fall-through FIFO. Transmit
// bytes wait in a one-entry holding register.
//
// Ports
//   avm_clk, avm_rst        clock, asynchronous active-high reset
//   avm_address/read/write  registered Avalon master command
//   avm_writedata           {24'b0, byte} for TX writes
//   avm_readdata            status word or received byte
//   avm_waitrequest         slave stall; command held while high
//   rx_data/rx_valid        FIFO head byte / FIFO not empty
//   rx_ready                consumer pops the head when rx_valid is high
//   tx_data/tx_valid        byte offered for transmission
//   tx_ready                holding register empty
//   fifo_count              RX FIFO occupancy
module rs232_avm_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DATA_ADDR   = 0,
  parameter int STATUS_ADDR = 8,
  parameter int RX_OK_BIT   = 7,
  parameter int TX_OK_BIT   = 6
) (
  input  logic                        avm_clk,
  input  logic                        avm_rst,
  output logic [4:0]                  avm_address,
  output logic                        avm_read,
  input  logic [31:0]                 avm_readdata,
  output logic                        avm_write,
  output logic [31:0]                 avm_writedata,
  input  logic                        avm_waitrequest,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [4:0]  DATA_A   = 5'(DATA_ADDR);
  localparam logic [4:0]  STATUS_A = 5'(STATUS_ADDR);

  typedef enum logic [1:0] {S_STATUS, S_DECIDE, S_RX_READ, S_TX_WRITE} state_t;

  state_t        state;
  logic          rx_ok;
  logic          tx_ok;
  logic          last_grant_tx;
  logic          tx_full;
  logic [7:0]    tx_hold;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rx_elig;
  logic          tx_elig;
  logic          push;
  logic          pop;
  logic          tx_take;
  logic          tx_done;
  logic          unused_readdata;

  // Only the flag bits and the low byte of the read word carry meaning.
  assign unused_readdata = ^avm_readdata;

  assign rx_elig  = rx_ok && (fifo_count < FULL_CNT);
  assign tx_elig  = tx_ok && tx_full;
  assign push     = (state == S_RX_READ) && avm_read && !avm_waitrequest;
  assign tx_done  = (state == S_TX_WRITE) && avm_write && !avm_waitrequest;
  assign pop      = rx_valid && rx_ready;
  assign tx_ready = ~tx_full;
  assign tx_take  = tx_valid && !tx_full;
  assign rx_valid = (fifo_count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  // Command FSM: strobes are loaded on the transition into each access state,
  // so a data access follows the decide cycle with no bubble. Out of reset the
  // status read has not been issued yet, which S_STATUS detects by a low strobe.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state         <= S_STATUS;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      rx_ok         <= 1'b0;
      tx_ok         <= 1'b0;
      last_grant_tx <= 1'b1;
    end else begin
      case (state)
        S_STATUS: begin
          if (!avm_read) begin
            avm_read    <= 1'b1;
            avm_address <= STATUS_A;
          end else if (!avm_waitrequest) begin
            rx_ok    <= avm_readdata[RX_OK_BIT];
            tx_ok    <= avm_readdata[TX_OK_BIT];
            avm_read <= 1'b0;
            state    <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          // On a tie, the side that did not win last time gets the grant.
          if (rx_elig && (!tx_elig || last_grant_tx)) begin
            state         <= S_RX_READ;
            avm_read      <= 1'b1;
            avm_address   <= DATA_A;
            last_grant_tx <= 1'b0;
          end else if (tx_elig) begin
            state         <= S_TX_WRITE;
            avm_write     <= 1'b1;
            avm_address   <= DATA_A;
            avm_writedata <= {24'h0, tx_hold};
            last_grant_tx <= 1'b1;
          end else begin
            state       <= S_STATUS;
            avm_read    <= 1'b1;
            avm_address <= STATUS_A;
          end
        end
        S_RX_READ: begin
          if (!avm_waitrequest) begin
            state       <= S_STATUS;
            avm_address <= STATUS_A;
          end
        end
        S_TX_WRITE: begin
          if (!avm_waitrequest) begin
            state       <= S_STATUS;
            avm_write   <= 1'b0;
            avm_read    <= 1'b1;
            avm_address <= STATUS_A;
          end
        end
        default: state <= S_STATUS;
      endcase
    end
  end

  // TX holding register control
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      tx_full <= 1'b0;
    end else if (tx_take) begin
      tx_full <= 1'b1;
    end else if (tx_done) begin
      tx_full <= 1'b0;
    end
  end

  always_ff @(posedge avm_clk) begin
    if (tx_take) begin
      tx_hold <= tx_data;
    end
  end

  // RX FIFO control: pointers wrap naturally at the power-of-two depth
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  always_ff @(posedge avm_clk) begin
    if (push) begin
      mem[wr_ptr] <= avm_readdata[7:0];
    end
  end

endmodule

// File: tb/tb_rs232_avm_scheduler.sv
// Bench for rs232_avm_scheduler: a UART slave stub answers the Avalon
// accesses, a scoreboard predicts every Avalon transaction kind, every popped
// RX byte and every written TX byte from arbitration rules kept at the level
// of "who is eligible and who went last".
module tb_rs232_avm_scheduler;

  localparam int DEPTH = 4;
  localparam int K_ST  = 0;
  localparam int K_RX  = 1;
  localparam int K_TX  = 2;
  localparam int K_BAD = 3;

  logic        clk = 1'b0;
  logic        avm_rst;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  rs232_avm_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
    .avm_clk(clk), .avm_rst(avm_rst),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_count(fifo_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- UART slave stub ----------------
  int          ws_cnt = 0;
  int          cur_wait = 0;
  int          wait_n;
  bit          wait_rand;
  bit          stat_random;
  bit          tx_ok_cfg;
  int          rx_avail;
  logic [7:0]  data_q[$];
  logic [31:0] stat_v = 0;
  logic [31:0] data_v = 0;

  always @(negedge clk) begin
    if (avm_rst) begin
      ws_cnt = 0;
    end else if (avm_read || avm_write) begin
      if (!avm_waitrequest) begin
        ws_cnt = 0;
        if (avm_read && avm_address == 5'd0 && rx_avail > 0) rx_avail--;
      end else begin
        ws_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (ws_cnt == 0) begin
      cur_wait = wait_rand ? int'($urandom_range(0, 2)) : wait_n;
      stat_v   = stat_random ? $urandom : {24'h0, (rx_avail > 0), tx_ok_cfg, 6'h0};
      if (avm_read && avm_address == 5'd0) begin
        data_v = $urandom;
        if (data_q.size() > 0) data_v[7:0] = data_q.pop_front();
      end
    end
    avm_waitrequest = (ws_cnt < cur_wait);
    avm_readdata    = (avm_address == 5'd8) ? stat_v : data_v;
  end

  // ---------------- random producers / consumer ----------------
  bit rx_auto;
  bit tx_auto;
  int tx_prob;

  always begin
    @(posedge clk);
    #1;
    if (rx_auto) rx_ready = 1'($urandom_range(0, 1));
  end

  always begin : txdrv
    bit hs;
    @(negedge clk);
    hs = tx_valid && tx_ready;
    @(posedge clk);
    #1;
    if (tx_auto && (hs || !tx_valid)) begin
      tx_valid = (int'($urandom_range(0, 99)) < tx_prob);
      tx_data  = 8'($urandom);
    end
  end

  // ---------------- reference model + monitor ----------------
  int          occ;
  bit          tx_pend;
  bit          last_tx;
  int          exp_ops[$];
  logic [7:0]  rx_exp[$];
  logic [7:0]  tx_exp[$];
  int          ops_log[$];
  bit          decide_now;
  bit          strobe_next;
  bit          stalled;
  logic [31:0] stat_s;
  logic [4:0]  sv_addr;
  logic [1:0]  sv_strb;
  logic [31:0] sv_wd;
  int          n_rx_reads = 0;
  int          n_tx = 0;

  always @(negedge clk) begin : mon
    int kind;
    int e;
    bit rx_e;
    bit tx_e;
    int inc;
    int dec;
    bit clr;
    bit set;
    logic [31:0] req;
    if (avm_rst) begin
      occ = 0; tx_pend = 0; last_tx = 1;
      exp_ops.delete(); exp_ops.push_back(K_ST);
      rx_exp.delete(); tx_exp.delete();
      decide_now = 0; strobe_next = 0; stalled = 0;
    end else begin
      inc = 0; dec = 0; clr = 0; set = 0;
      if (decide_now) begin
        decide_now = 0;
        check("decide_idle", {30'h0, avm_read, avm_write}, 32'h0);
        rx_e = stat_s[7] && (occ < DEPTH);
        tx_e = stat_s[6] && tx_pend;
        if (rx_e && tx_e) kind = last_tx ? K_RX : K_TX;
        else if (rx_e)    kind = K_RX;
        else if (tx_e)    kind = K_TX;
        else              kind = K_ST;
        if (kind == K_RX) last_tx = 0;
        else if (kind == K_TX) last_tx = 1;
        exp_ops.push_back(kind);
        strobe_next = 1;
      end else if (strobe_next) begin
        strobe_next = 0;
        check("no_idle_gap", avm_read | avm_write, 1);
      end
      check("fifo_count", fifo_count, occ);
      check("rx_valid", rx_valid, occ != 0);
      check("tx_ready", tx_ready, !tx_pend);
      check("rd_wr_excl", avm_read & avm_write, 0);
      if (stalled) begin
        check("hold_addr", avm_address, sv_addr);
        check("hold_strobe", {avm_read, avm_write}, sv_strb);
        check("hold_wdata", avm_writedata, sv_wd);
      end
      stalled = (avm_read || avm_write) && avm_waitrequest;
      sv_addr = avm_address; sv_strb = {avm_read, avm_write}; sv_wd = avm_writedata;

      if (rx_valid && rx_ready) begin
        req = (rx_exp.size() > 0) ? {24'h0, rx_exp.pop_front()} : 32'h100;
        check("rx_data_pop", {24'h0, rx_data}, req);
        dec = (occ > 0) ? 1 : 0;
      end

      if ((avm_read || avm_write) && !avm_waitrequest) begin
        if (avm_read && avm_address == 5'd8)       kind = K_ST;
        else if (avm_read && avm_address == 5'd0)  kind = K_RX;
        else if (avm_write && avm_address == 5'd0) kind = K_TX;
        else                                       kind = K_BAD;
        e = (exp_ops.size() > 0) ? exp_ops.pop_front() : K_BAD + 1;
        check("op_kind", kind, e);
        case (kind)
          K_ST: begin
            stat_s = avm_readdata;
            decide_now = 1;
          end
          K_RX: begin
            rx_exp.push_back(avm_readdata[7:0]);
            inc = 1; n_rx_reads++; ops_log.push_back(K_RX);
            exp_ops.push_back(K_ST); strobe_next = 1;
          end
          K_TX: begin
            req = (tx_exp.size() > 0) ? {24'h0, tx_exp.pop_front()} : 32'hFFFF_FFFF;
            check("tx_wdata", avm_writedata, req);
            clr = 1; n_tx++; ops_log.push_back(K_TX);
            exp_ops.push_back(K_ST); strobe_next = 1;
          end
          default: ;
        endcase
      end

      if (tx_valid && tx_ready) begin
        tx_exp.push_back(tx_data);
        set = 1;
      end
      occ = occ + inc - dec;
      if (clr) tx_pend = 0;
      if (set) tx_pend = 1;
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int cyc;
    int base;
    avm_rst = 1; rx_ready = 0; tx_valid = 0; tx_data = 0;
    wait_n = 0; wait_rand = 0; stat_random = 0; tx_ok_cfg = 0; rx_avail = 0;
    rx_auto = 0; tx_auto = 0; tx_prob = 100;
    avm_waitrequest = 0; avm_readdata = 0;
    repeat (3) tick();
    check("rst_read", avm_read, 0);
    check("rst_write", avm_write, 0);
    check("rst_addr", avm_address, 0);
    check("rst_wdata", avm_writedata, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);

    // Reset in the middle of a stalled status read
    wait_n = 1000;
    avm_rst = 0;
    cyc = 0;
    while (!avm_read && cyc < 20) begin tick(); cyc++; end
    check("pre_rst_read", avm_read, 1);
    #1 avm_rst = 1;
    #1;
    check("rst_async_read", avm_read, 0);
    check("rst_async_addr", avm_address, 0);
    wait_n = 0;
    tick();
    #1 avm_rst = 0;
    #1;
    check("post_rst_tx_ready", tx_ready, 1);
    check("post_rst_rx_valid", rx_valid, 0);
    cyc = 0;
    while (!(avm_read || avm_write) && cyc < 20) begin tick(); cyc++; end
    check("first_strobe_read", avm_read, 1);
    check("first_strobe_write", avm_write, 0);
    check("first_addr", avm_address, 8);

    // Single received byte
    base = n_rx_reads;
    data_q.push_back(8'h41);
    rx_avail = 1;
    cyc = 0;
    while (n_rx_reads == base && cyc < 60) begin tick(); cyc++; end
    check("rx1_valid", rx_valid, 1);
    check("rx1_data", rx_data, 8'h41);
    check("rx1_count", fifo_count, 1);
    rx_ready = 1;
    tick();
    rx_ready = 0;
    check("rx1_pop_count", fifo_count, 0);

    // Single transmitted byte
    tx_ok_cfg = 1;
    tx_data = 8'h5A; tx_valid = 1;
    cyc = 0;
    while (tx_ready && cyc < 20) begin tick(); cyc++; end
    tx_valid = 0;
    base = n_tx;
    cyc = 0;
    while (!avm_write && cyc < 60) begin tick(); cyc++; end
    check("tx1_write", avm_write, 1);
    check("tx1_addr", avm_address, 0);
    check("tx1_wdata", avm_writedata, 32'h0000_005A);
    cyc = 0;
    while (n_tx == base && cyc < 60) begin tick(); cyc++; end
    check("tx1_ready_after", tx_ready, 1);

    // Arbitration with both sides always eligible
    rx_avail = 100000; tx_ok_cfg = 1; rx_ready = 1; tx_prob = 100; tx_auto = 1;
    repeat (12) tick();
    ops_log.delete();
    repeat (60) tick();
    check("arb_ops_seen", ops_log.size() >= 10, 1);
    for (int i = 1; i < ops_log.size(); i++)
      check("arb_alternate", ops_log[i], (ops_log[i-1] == K_RX) ? K_TX : K_RX);
    tx_auto = 0; tx_valid = 0; rx_avail = 0;
    repeat (20) tick();

    // FIFO full back-pressure
    rx_ready = 0; tx_ok_cfg = 0; rx_avail = 100000;
    base = n_rx_reads;
    repeat (60) tick();
    check("full_reads", n_rx_reads - base, DEPTH);
    check("full_count", fifo_count, DEPTH);
    rx_ready = 1;
    tick();
    rx_ready = 0;
    repeat (40) tick();
    check("refill_reads", n_rx_reads - base, DEPTH + 1);
    check("refill_count", fifo_count, DEPTH);
    rx_avail = 0; rx_ready = 1;
    repeat (20) tick();
    check("drained_count", fifo_count, 0);

    // Three wait states on every access
    rx_ready = 0; wait_n = 3;
    data_q.push_back(8'h11); data_q.push_back(8'h22); data_q.push_back(8'h33);
    base = n_rx_reads;
    rx_avail = 3;
    cyc = 0;
    while (n_rx_reads < base + 3 && cyc < 200) begin tick(); cyc++; end
    tick();
    check("ws_rx_count", fifo_count, 3);
    check("ws_rx_head", rx_data, 8'h11);
    rx_ready = 1;
    repeat (5) tick();
    check("ws_rx_drained", fifo_count, 0);
    tx_ok_cfg = 1; tx_data = 8'hA5; tx_valid = 1;
    cyc = 0;
    while (tx_ready && cyc < 20) begin tick(); cyc++; end
    tx_valid = 0;
    base = n_tx;
    cyc = 0;
    while (!avm_write && cyc < 100) begin tick(); cyc++; end
    cyc = 0;
    while (n_tx == base && cyc < 100) begin tick(); cyc++; end
    check("ws_tx_cycles", cyc, 4);

    // Randomized traffic
    wait_n = 0; wait_rand = 1; stat_random = 1;
    rx_auto = 1; tx_prob = 50; tx_auto = 1;
    repeat (3000) tick();
    stat_random = 0; rx_avail = 0; tx_ok_cfg = 1; wait_rand = 0;
    rx_auto = 0; tx_auto = 0;
    tick();
    tx_valid = 0; rx_ready = 1;
    repeat (60) tick();
    check("end_fifo_count", fifo_count, 0);
    check("end_tx_ready", tx_ready, 1);
    check("end_rx_sb_empty", rx_exp.size(), 0);
    check("end_tx_sb_empty", tx_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rs232_avm_scheduler.md
Name: rs232_avm_scheduler

Overview:
Avalon-MM master controller that shares the single RS232 UART port between a receive stream and a transmit requester. It continuously polls the UART status register and performs one data read or one data write per poll. Received bytes are buffered in a small FIFO for the pixel/command consumer. Transmit bytes come from a one-entry holding register. It sits between the UART core and the design's byte producers and consumers, alongside the VGA path.

Parameters:
FIFO_DEPTH, 4, RX FIFO entries; power of two, at least 2
DATA_ADDR, 0, word address of the UART RX/TX data register
STATUS_ADDR, 8, word address of the UART status register
RX_OK_BIT, 7, status bit: received byte available
TX_OK_BIT, 6, status bit: transmitter can accept a byte

Ports:
avm_clk  in  1  system clock
avm_rst  in  1  reset, asynchronous, active-high
avm_address  out  5  Avalon address
avm_read  out  1  Avalon read strobe
avm_readdata  in  32  Avalon read data
avm_write  out  1  Avalon write strobe
avm_writedata  out  32  Avalon write data, {24'b0, byte}
avm_waitrequest  in  1  Avalon stall
rx_data  out  8  FIFO head byte
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer pops the head when rx_valid is also high
tx_data  in  8  byte to transmit
tx_valid  in  1  transmit request
tx_ready  out  1  holding register empty
fifo_count  out  clog2(FIFO_DEPTH)+1  RX FIFO occupancy

Behaviour:
- Reset: asynchronous, active-high; takes effect immediately, mid-transaction included.
  - Reset values: avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, rx_valid=0, fifo_count=0, tx_ready=1, rx_data=0.
  - FSM goes to S_STATUS; last_grant=TX, so RX wins the first tie.
  - An aborted Avalon transaction is not resumed.
- Avalon rules:
  - avm_address, avm_read, avm_write and avm_writedata are registered.
  - They hold stable while avm_waitrequest=1.
  - A transaction completes on the cycle the strobe is high and avm_waitrequest=0.
  - avm_readdata is sampled on that cycle.
  - Read and write are never high together.
- FSM states:
  - S_STATUS: read=1, addr=STATUS_ADDR. On completion, latch rx_ok=readdata[RX_OK_BIT] and tx_ok=readdata[TX_OK_BIT], then go to S_DECIDE.
  - S_DECIDE: 1 cycle, all strobes 0.
    - rx_elig = rx_ok & (fifo_count < FIFO_DEPTH).
    - tx_elig = tx_ok & tx_full.
    - Both eligible: grant the side opposite last_grant.
    - One eligible: grant it.
    - None eligible: go to S_STATUS.
    - Update last_grant only when a grant is made.
  - S_RX_READ: read=1, addr=DATA_ADDR. On completion, push readdata[7:0] into the FIFO, then go to S_STATUS.
  - S_TX_WRITE: write=1, addr=DATA_ADDR, writedata={24'b0, tx_hold}. On completion, clear tx_full, then go to S_STATUS.
- TX holding register:
  - tx_ready = ~tx_full.
  - When tx_valid & tx_ready: capture tx_data into tx_hold and set tx_full; tx_ready reads 0 on the next cycle.
  - tx_ready returns to 1 on the cycle after write completion.
  - tx_hold never changes while tx_full=1.
- RX FIFO:
  - First-word-fall-through: rx_data shows the head and rx_valid=(count!=0). Data is visible the cycle after the push.
  - Pop when rx_valid & rx_ready.
  - Push and pop on the same cycle: count unchanged, data order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow is impossible: no data read is issued when full. A pop while empty is ignored.
- Throughput: the minimum per-byte cost with zero wait states is 3 cycles (status, decide, data).

Test Plan:
1. Reset mid-read: avm_read=1 with waitrequest held 1, assert avm_rst -> avm_read=0 in the same cycle without a clock edge; after release, tx_ready=1, rx_valid=0 and the first strobe is a status read to addr 8.
2. RX path: status readdata=0x80, then data readdata=0x41 -> rx_valid=1 and rx_data=0x41 one cycle after data-read completion; fifo_count=1; rx_ready=1 pops it, giving fifo_count=0.
3. TX path: tx_valid with tx_data=0x5A, status readdata=0x40 -> avm_write with addr 0 and writedata 0x0000005A; tx_ready=1 the cycle after completion.
4. Arbitration: tx pending and status=0xC0 on every poll, tx refilled each time -> data operations alternate RX, TX, RX, TX.
5. FIFO full: FIFO_DEPTH=4, rx_ready=0, status=0x80 -> exactly 4 data reads, then only status reads. One pop -> exactly one more data read follows.
6. Wait states: waitrequest=1 for 3 cycles on each access -> address, strobe and writedata stay stable and each access completes on the 4th cycle; the byte ordering of scenario 2 is unchanged.
